// File: rtl/mips_div_unit.sv
// rtl/mips_div_unit.sv - multi-cycle restoring divider producing LO (quotient) and HI (remainder)
// Optional abort input enabled by defining DIV_ABORT_EN.
module mips_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
`ifdef DIV_ABORT_EN
    input  logic             abort,
`endif
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } state_t;

    state_t state, state_next;

    logic [WIDTH-1:0] dvd;
    logic [WIDTH-1:0] dsr;
    logic [WIDTH-1:0] rem;
    logic [CW-1:0]    count;
    logic             neg_q;
    logic             neg_r;

    logic             abort_hit;
    logic             sign_a;
    logic             sign_b;
    logic [WIDTH-1:0] dvd_abs;
    logic [WIDTH-1:0] dsr_abs;
    logic [WIDTH-1:0] rem_shift;
    logic [WIDTH:0]   trial;

`ifdef DIV_ABORT_EN
    assign abort_hit = abort;
`else
    assign abort_hit = 1'b0;
`endif

    assign sign_a  = is_signed & dividend[WIDTH-1];
    assign sign_b  = is_signed & divisor[WIDTH-1];
    // Negating the most-negative value yields itself, i.e. magnitude 2^(WIDTH-1) read unsigned
    assign dvd_abs = sign_a ? -dividend : dividend;
    assign dsr_abs = sign_b ? -divisor : divisor;

    assign rem_shift = {rem[WIDTH-2:0], dvd[WIDTH-1]};
    assign trial     = {1'b0, rem_shift} - {1'b0, dsr};

    assign busy = (state == CALC) || (state == FIX);
    assign done = (state == DONE);

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = (divisor == '0) ? DONE : CALC;
                end
            end
            CALC: begin
                if (abort_hit) begin
                    state_next = IDLE;
                end else if (count == LAST_STEP) begin
                    state_next = FIX;
                end
            end
            FIX: begin
                state_next = abort_hit ? IDLE : DONE;
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dvd         <= '0;
            dsr         <= '0;
            rem         <= '0;
            count       <= '0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        dvd   <= dvd_abs;
                        dsr   <= dsr_abs;
                        rem   <= '0;
                        count <= '0;
                        neg_q <= sign_a ^ sign_b;
                        neg_r <= sign_a;
                        if (divisor == '0) begin
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                        end
                    end
                end
                CALC: begin
                    // dvd doubles as the quotient shift register as dividend bits move into rem
                    if (!trial[WIDTH]) begin
                        rem <= trial[WIDTH-1:0];
                        dvd <= {dvd[WIDTH-2:0], 1'b1};
                    end else begin
                        rem <= rem_shift;
                        dvd <= {dvd[WIDTH-2:0], 1'b0};
                    end
                    count <= count + 1'b1;
                end
                FIX: begin
                    if (!abort_hit) begin
                        quotient    <= neg_q ? -dvd : dvd;
                        remainder   <= neg_r ? -rem : rem;
                        div_by_zero <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mips_div_unit.sv
// tb/tb_mips_div_unit.sv - scoreboard bench for mips_div_unit
module tb_mips_div_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         is_signed;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;
`ifdef DIV_ABORT_EN
    logic         abort = 1'b0;
`endif

    mips_div_unit #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
`ifdef DIV_ABORT_EN
        .abort       (abort),
`endif
        .is_signed   (is_signed),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         z;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    function automatic exp_t model(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t   e;
        longint sa;
        longint sd;
        if (b == '0) begin
            e.q = '1;
            e.r = a;
            e.z = 1'b1;
        end else if (sgn) begin
            sa  = $signed(a);
            sd  = $signed(b);
            e.q = W'(sa / sd);
            e.r = W'(sa % sd);
            e.z = 1'b0;
        end else begin
            e.q = a / b;
            e.r = a % b;
            e.z = 1'b0;
        end
        return e;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (!rst && done) begin
            if (sbq.size() == 0) begin
                check("spurious_done", 1, 0);
            end else begin
                e = sbq.pop_front();
                check("quotient", quotient, e.q);
                check("remainder", remainder, e.r);
                check("div_by_zero", div_by_zero, e.z);
                check("busy_at_done", busy, 0);
            end
        end
    end

    // Drives one division; start edge counts as edge 1, optionally spraying ignored starts
    task automatic run_div(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                           input int exp_lat, input bit extra);
        int lat;
        int busy_n;
        sbq.push_back(model(sgn, a, b));
        @(negedge clk);
        start = 1'b1; is_signed = sgn; dividend = a; divisor = b;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        busy_n = 0;
        while (!done && lat < 200) begin
            if (busy) busy_n++;
            if (extra && (lat % 5 == 0)) begin
                start = 1'b1; dividend = $urandom; divisor = $urandom_range(0, 3);
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        check("latency", lat, exp_lat);
        check("busy_cycles", busy_n, exp_lat - 1);
    endtask

    initial begin
        logic         sgn;
        logic [W-1:0] a;
        logic [W-1:0] b;
        rst = 1'b1; start = 1'b0; is_signed = 1'b0; dividend = '0; divisor = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_quotient", quotient, 0);
        check("rst_remainder", remainder, 0);
        check("rst_dbz", div_by_zero, 0);
        rst = 1'b0;

        run_div(1'b0, 32'd100, 32'd7, 34, 1'b0);
        check("q_100_7", quotient, 32'd14);
        check("r_100_7", remainder, 32'd2);

        run_div(1'b1, -32'sd7, 32'd2, 34, 1'b1);
        check("q_m7_2", quotient, 32'hFFFF_FFFD);
        check("r_m7_2", remainder, 32'hFFFF_FFFF);

        run_div(1'b1, 32'd7, -32'sd2, 34, 1'b0);
        check("q_7_m2", quotient, 32'hFFFF_FFFD);
        check("r_7_m2", remainder, 32'd1);

        run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 34, 1'b0);
        check("q_ovf", quotient, 32'h8000_0000);
        check("r_ovf", remainder, 32'd0);

        run_div(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 34, 1'b0);
        check("q_u_big", quotient, 32'd0);
        check("r_u_big", remainder, 32'h8000_0000);

        run_div(1'b0, 32'h1234, 32'd0, 1, 1'b0);
        check("q_dz", quotient, 32'hFFFF_FFFF);
        check("r_dz", remainder, 32'h1234);
        check("flag_dz", div_by_zero, 1);

        run_div(1'b1, 32'd50, 32'd5, 34, 1'b0);
        check("flag_cleared", div_by_zero, 0);

        for (int i = 0; i < 8; i++) begin
            sgn = 1'($urandom);
            a = $urandom;
            b = (i == 3) ? '0 : ((i % 2) ? 32'($urandom_range(1, 300)) : $urandom);
            if (sgn && (i == 5)) b = -32'sd13;
            run_div(sgn, a, b, (b == '0) ? 1 : 34, 1'b1);
        end

        run_div(1'b0, 32'd1000, 32'd3, 34, 1'b0);
        repeat (5) @(negedge clk);
        check("hold_q", quotient, 32'd333);
        check("hold_r", remainder, 32'd1);

`ifdef DIV_ABORT_EN
        begin
            int lat;
            @(negedge clk);
            start = 1'b1; is_signed = 1'b0; dividend = 32'd999; divisor = 32'd4;
            @(negedge clk);
            start = 1'b0;
            repeat (3) @(negedge clk);
            abort = 1'b1;
            @(negedge clk);
            abort = 1'b0;
            check("abort_busy", busy, 0);
            check("abort_keep_q", quotient, 32'd333);
            @(negedge clk);
            sbq.push_back(model(1'b1, -32'sd77, 32'd5));
            start = 1'b1; is_signed = 1'b1; dividend = -32'sd77; divisor = 32'd5;
            @(negedge clk);
            start = 1'b0;
            lat = 7;
            while (!done && lat < 200) begin
                @(negedge clk);
                lat++;
            end
            check("abort_restart_lat", lat, 41);
        end
`endif

        // Reset in the middle of a divide, with stray starts while busy
        @(negedge clk);
        start = 1'b1; is_signed = 1'b0; dividend = 32'd500; divisor = 32'd9;
        @(negedge clk);
        for (int i = 2; i < 10; i++) begin
            start = (i % 3 == 0);
            @(negedge clk);
        end
        start = 1'b0;
        check("pre_rst_busy", busy, 1);
        rst = 1'b1;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_q", quotient, 0);
        check("mid_rst_r", remainder, 0);
        check("mid_rst_dbz", div_by_zero, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (50) @(negedge clk);
        check("sb_empty", sbq.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
